// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: ROB tag sizing,
// requester indices and the round-robin pointer helper.
package cdb_arbiter_pkg;

  localparam int ROB_SZ_LOG = 4;
  localparam int CDB_NREQ   = 4;

  typedef enum logic [1:0] {
    CDB_ALU0 = 2'd0,
    CDB_ALU1 = 2'd1,
    CDB_LOAD = 2'd2,
    CDB_STR  = 2'd3
  } cdb_src_e;

  // Priority moves to the requester just after the one that won.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of valid_i at or after ptr_i,
// wrapping, returned as a one-hot grant plus its encoded index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o
);

  logic          found;
  logic [PW:0]   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_i} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && valid_i[cand[PW-1:0]]) begin
        found                  = 1'b1;
        grant_o[cand[PW-1:0]]  = 1'b1;
        idx_o                  = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per result producer, a
// round-robin grant per cycle, and a registered broadcast of the winner.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ = CDB_NREQ,
  parameter int IDW  = ROB_SZ_LOG + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IDW-1:0]  req_rob_id,
  input  logic [NREQ*32-1:0]   req_res,
  input  logic [NREQ*32-1:0]   req_res2,
  output logic [NREQ-1:0]      req_ready,
  output logic                 cdb_valid,
  output logic [IDW-1:0]       cdb_rob_id,
  output logic [31:0]          cdb_res,
  output logic [31:0]          cdb_res2,
  output logic [1:0]           cdb_src
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] buf_v_q, buf_v_d;
  logic [IDW-1:0]  buf_id_q   [NREQ];
  logic [IDW-1:0]  buf_id_d   [NREQ];
  logic [31:0]     buf_res_q  [NREQ];
  logic [31:0]     buf_res_d  [NREQ];
  logic [31:0]     buf_res2_q [NREQ];
  logic [31:0]     buf_res2_d [NREQ];
  logic [PW-1:0]   ptr_q, ptr_d;

  logic            cdb_v_q, cdb_v_d;
  logic [IDW-1:0]  cdb_id_q, cdb_id_d;
  logic [31:0]     cdb_res_q, cdb_res_d;
  logic [31:0]     cdb_res2_q, cdb_res2_d;
  logic [1:0]      cdb_src_q, cdb_src_d;

  logic [NREQ-1:0] pick_gnt, gnt, accept;
  logic [PW-1:0]   gnt_idx;
  logic            live;

  // Grants come from registered valids only, so a buffer written at an edge
  // cannot win until the following cycle.
  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid_i (buf_v_q),
    .ptr_i   (ptr_q),
    .grant_o (pick_gnt),
    .idx_o   (gnt_idx)
  );

  // Handshake: a result transfers on an edge where req_valid[i] & req_ready[i];
  // req_ready[i] is high when buffer i is empty or is being drained this cycle.
  assign live      = rdy & ~flush;
  assign gnt       = pick_gnt & {NREQ{live}};
  assign req_ready = {NREQ{live}} & (~buf_v_q | gnt);
  assign accept    = req_valid & req_ready;

  always_comb begin
    buf_v_d    = buf_v_q;
    buf_id_d   = buf_id_q;
    buf_res_d  = buf_res_q;
    buf_res2_d = buf_res2_q;
    ptr_d      = ptr_q;
    cdb_v_d    = cdb_v_q;
    cdb_id_d   = cdb_id_q;
    cdb_res_d  = cdb_res_q;
    cdb_res2_d = cdb_res2_q;
    cdb_src_d  = cdb_src_q;
    if (rdy) begin
      if (flush) begin
        buf_v_d = '0;
        cdb_v_d = 1'b0;
      end else begin
        cdb_v_d = |gnt;
        if (|gnt) begin
          cdb_id_d   = buf_id_q[gnt_idx];
          cdb_res_d  = buf_res_q[gnt_idx];
          cdb_res2_d = buf_res2_q[gnt_idx];
          cdb_src_d  = 2'(gnt_idx);
          ptr_d      = PW'(rr_next(int'(gnt_idx), NREQ));
        end
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) buf_v_d[i] = 1'b0;
          if (accept[i]) begin
            buf_v_d[i]    = 1'b1;
            buf_id_d[i]   = req_rob_id[i*IDW +: IDW];
            buf_res_d[i]  = req_res[i*32 +: 32];
            buf_res2_d[i] = req_res2[i*32 +: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q    <= '0;
      ptr_q      <= '0;
      cdb_v_q    <= 1'b0;
      cdb_id_q   <= '0;
      cdb_res_q  <= '0;
      cdb_res2_q <= '0;
      cdb_src_q  <= '0;
    end else begin
      buf_v_q    <= buf_v_d;
      ptr_q      <= ptr_d;
      cdb_v_q    <= cdb_v_d;
      cdb_id_q   <= cdb_id_d;
      cdb_res_q  <= cdb_res_d;
      cdb_res2_q <= cdb_res2_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  // Payload storage is qualified by buf_v_q and needs no reset.
  always_ff @(posedge clk) begin
    buf_id_q   <= buf_id_d;
    buf_res_q  <= buf_res_d;
    buf_res2_q <= buf_res2_d;
  end

  assign cdb_valid  = cdb_v_q;
  assign cdb_rob_id = cdb_id_q;
  assign cdb_res    = cdb_res_q;
  assign cdb_res2   = cdb_res2_q;
  assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for arbitration, flush and
// stall behaviour, plus hand sequences for stall freeze, saturation and reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = ROB_SZ_LOG + 1;

  logic                clk = 1'b0;
  logic                rst, rdy, flush;
  logic [NREQ-1:0]     req_valid, req_ready;
  logic [NREQ*IDW-1:0] req_rob_id;
  logic [NREQ*32-1:0]  req_res, req_res2;
  logic                cdb_valid;
  logic [IDW-1:0]      cdb_rob_id;
  logic [31:0]         cdb_res, cdb_res2;
  logic [1:0]          cdb_src;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  cdb_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_rob_id (req_rob_id),
    .req_res    (req_res),
    .req_res2   (req_res2),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_res    (cdb_res),
    .cdb_res2   (cdb_res2),
    .cdb_src    (cdb_src)
  );

  // Payload of requester i in a transaction tagged t.
  function automatic logic [IDW-1:0] pid(input int t, input int i);
    return IDW'(t + i);
  endfunction

  function automatic logic [31:0] pres(input int t, input int i);
    return 32'(t * 16 + i);
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic [3:0] v, input int t);
    rdy       = r;
    flush     = f;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_rob_id[i*IDW +: IDW] = pid(t, i);
      req_res[i*32 +: 32]      = pres(t, i);
      req_res2[i*32 +: 32]     = ~pres(t, i);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0000, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_cdb(input string name, input int t, input int src);
    chk({name, "_valid"}, 80'(cdb_valid), 80'(1));
    chk({name, "_payload"}, 80'({cdb_rob_id, cdb_res, cdb_res2, cdb_src}),
        80'({pid(t, src), pres(t, src), ~pres(t, src), 2'(src)}));
  endtask

  typedef struct {
    logic       rdy;
    logic       flush;
    logic [3:0] v;
    int         t;
    logic [3:0] exp_rdy;
    logic       exp_cv;
    int         exp_src;
    int         exp_t;
  } vec_t;

  vec_t vecs[23];
  int   src_cnt[NREQ];

  function automatic vec_t mk(input logic r, input logic f, input logic [3:0] v, input int t,
                              input logic [3:0] er, input logic ecv, input int es, input int et);
    vec_t x;
    x.rdy = r; x.flush = f; x.v = v; x.t = t;
    x.exp_rdy = er; x.exp_cv = ecv; x.exp_src = es; x.exp_t = et;
    return x;
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 4'b0000, 0);

    vecs[0]  = mk(1, 0, 4'b0000, 0, 4'b1111, 0, 0, 0);
    vecs[1]  = mk(1, 0, 4'b1111, 1, 4'b1111, 0, 0, 0);  // all four at one edge, ptr 0
    vecs[2]  = mk(1, 0, 4'b0000, 0, 4'b0001, 1, 0, 1);
    vecs[3]  = mk(1, 0, 4'b0000, 0, 4'b0011, 1, 1, 1);
    vecs[4]  = mk(1, 0, 4'b0000, 0, 4'b0111, 1, 2, 1);
    vecs[5]  = mk(1, 0, 4'b0000, 0, 4'b1111, 1, 3, 1);
    vecs[6]  = mk(1, 0, 4'b0000, 0, 4'b1111, 0, 0, 0);
    vecs[7]  = mk(1, 0, 4'b0001, 1, 4'b1111, 0, 0, 0);  // single ALU0 request
    vecs[8]  = mk(1, 0, 4'b0000, 0, 4'b1111, 1, 0, 1);
    vecs[9]  = mk(1, 0, 4'b0000, 0, 4'b1111, 0, 0, 0);
    vecs[10] = mk(1, 0, 4'b0001, 2, 4'b1111, 0, 0, 0);
    vecs[11] = mk(1, 0, 4'b1000, 3, 4'b1111, 1, 0, 2);  // ptr 1 wraps to buffer 0
    vecs[12] = mk(1, 0, 4'b0001, 4, 4'b1111, 1, 3, 3);
    vecs[13] = mk(1, 0, 4'b0001, 5, 4'b1111, 1, 0, 4);  // granted buffer refilled
    vecs[14] = mk(1, 0, 4'b0000, 0, 4'b1111, 1, 0, 5);
    vecs[15] = mk(1, 0, 4'b0110, 6, 4'b1111, 0, 0, 0);
    vecs[16] = mk(1, 1, 4'b0100, 7, 4'b0000, 0, 0, 0);  // flush with new LOAD
    vecs[17] = mk(1, 0, 4'b0000, 0, 4'b1111, 0, 0, 0);
    vecs[18] = mk(1, 0, 4'b0000, 0, 4'b1111, 0, 0, 0);
    vecs[19] = mk(0, 1, 4'b1111, 8, 4'b0000, 0, 0, 0);  // stalled, flush ignored
    vecs[20] = mk(1, 0, 4'b0000, 0, 4'b1111, 0, 0, 0);
    vecs[21] = mk(1, 0, 4'b0010, 9, 4'b1111, 0, 0, 0);
    vecs[22] = mk(1, 0, 4'b0000, 0, 4'b1111, 1, 1, 9);  // ptr held across flush

    do_reset();
    chk("reset_cdb", 80'({cdb_valid, cdb_rob_id, cdb_res, cdb_res2, cdb_src}), 80'(0));
    chk("reset_ready", 80'(req_ready), 80'(4'b1111));

    for (int r = 0; r < 23; r++) begin
      drive(vecs[r].rdy, vecs[r].flush, vecs[r].v, vecs[r].t);
      #1;
      chk($sformatf("vec%0d_ready", r), 80'(req_ready), 80'(vecs[r].exp_rdy));
      tick();
      if (vecs[r].exp_cv) chk_cdb($sformatf("vec%0d", r), vecs[r].exp_t, vecs[r].exp_src);
      else chk($sformatf("vec%0d_valid", r), 80'(cdb_valid), 80'(0));
    end

    // Stall: cdb shows ALU0 id 5 while LOAD waits in its buffer.
    do_reset();
    drive(1'b1, 1'b0, 4'b0101, 5);
    tick();
    drive(1'b1, 1'b0, 4'b0000, 0);
    tick();
    chk_cdb("stall_pre", 5, 0);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 4'b1111, 8);
      #1;
      chk("stall_ready", 80'(req_ready), 80'(0));
      tick();
      chk_cdb("stall_hold", 5, 0);
    end
    drive(1'b1, 1'b0, 4'b0000, 0);
    #1;
    chk("stall_resume_ready", 80'(req_ready), 80'(4'b1111));
    tick();
    chk_cdb("stall_load", 5, 2);
    tick();
    chk("stall_drained", 80'(cdb_valid), 80'(0));

    // Saturation: all four held valid; round robin from ptr 0.
    do_reset();
    drive(1'b1, 1'b0, 4'b1111, 10);
    tick();
    for (int k = 0; k < 12; k++) exp_q.push_back(2'(k % NREQ));
    for (int i = 0; i < NREQ; i++) src_cnt[i] = 0;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] e;
      tick();
      e = exp_q.pop_front();
      chk($sformatf("sat%0d", k), 80'({cdb_valid, cdb_src}), 80'({1'b1, e}));
      if (cdb_valid) src_cnt[cdb_src]++;
    end
    for (int i = 0; i < NREQ; i++) chk($sformatf("sat_count%0d", i), 80'(src_cnt[i]), 80'(3));

    // Reset with three buffers still full discards them.
    drive(1'b1, 1'b0, 4'b0000, 0);
    tick();
    chk("pre_rst_valid", 80'(cdb_valid), 80'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cdb", 80'({cdb_valid, cdb_rob_id, cdb_res, cdb_res2, cdb_src}), 80'(0));
    tick();
    chk("rst_discard", 80'(cdb_valid), 80'(0));
    drive(1'b1, 1'b0, 4'b1000, 11);
    tick();
    chk("store_not_yet", 80'(cdb_valid), 80'(0));
    drive(1'b1, 1'b0, 4'b0000, 0);
    tick();
    chk_cdb("store", 11, int'(CDB_STR));
    tick();
    chk("store_once", 80'(cdb_valid), 80'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
